// File: rtl/seq_comparator_pkg.sv
// ============================================================================
//  Module   : seq_comparator_pkg
//  Purpose  : Shared types and helpers for the multi-cycle magnitude comparator.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package seq_comparator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } cmp_state_t;

   function automatic int slice_count(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_comparator_if.sv
// ============================================================================
//  Module   : seq_comparator_if
//  Purpose  : Start/busy/done handshake, operands and result flags.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface seq_comparator_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             a_greater_b;
   logic             a_equals_b;
   logic             a_smaller_b;

   modport master (
      output start, is_signed, a, b,
      input  busy, done, a_greater_b, a_equals_b, a_smaller_b
   );

   modport slave (
      input  start, is_signed, a, b,
      output busy, done, a_greater_b, a_equals_b, a_smaller_b
   );
endinterface

`default_nettype wire

// File: rtl/seq_comparator_cmp_slice.sv
// ============================================================================
//  Module   : cmp_slice
//  Purpose  : Combinational unsigned compare of one CHUNK-bit slice.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module cmp_slice
   import seq_comparator_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   output logic             gt,
   output logic             eq
);

   assign gt = (x > y);
   assign eq = (x == y);

endmodule

`default_nettype wire

// File: rtl/seq_comparator.sv
// ============================================================================
//  Module   : seq_comparator
//  Purpose  : MSB-first multi-cycle signed/unsigned comparator with early exit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seq_comparator
   import seq_comparator_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic                clk,
   input  logic                rst,
   seq_comparator_if.slave     bus
);

   localparam int N  = slice_count(WIDTH, CHUNK);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0]    IDX_TOP  = IW'(N - 1);
   localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

   if ((WIDTH % CHUNK) != 0 || CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_params
      $error("seq_comparator: WIDTH must be a positive multiple of CHUNK");
   end

   cmp_state_t       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_signed;
   logic [IW-1:0]    r_idx;
   logic             r_busy;
   logic             r_done;
   logic             r_gt;
   logic             r_eq;
   logic             r_lt;

   logic [CHUNK-1:0] w_a_sl [N];
   logic [CHUNK-1:0] w_b_sl [N];
   logic [CHUNK-1:0] w_a_cur;
   logic [CHUNK-1:0] w_b_cur;
   logic [CHUNK-1:0] w_x;
   logic [CHUNK-1:0] w_y;
   logic             w_flip;
   logic             w_gt;
   logic             w_eq;

   for (genvar g = 0; g < N; g++) begin : g_slices
      assign w_a_sl[g] = r_a[g*CHUNK +: CHUNK];
      assign w_b_sl[g] = r_b[g*CHUNK +: CHUNK];
   end

   if (N == 1) begin : g_single
      assign w_a_cur = w_a_sl[0];
      assign w_b_cur = w_b_sl[0];
   end else begin : g_multi
      assign w_a_cur = w_a_sl[r_idx];
      assign w_b_cur = w_b_sl[r_idx];
   end

   // Offset-binary: flipping both sign bits turns a signed compare into unsigned.
   assign w_flip = r_signed && (r_idx == IDX_TOP);
   assign w_x    = w_a_cur ^ (w_flip ? MSB_MASK : '0);
   assign w_y    = w_b_cur ^ (w_flip ? MSB_MASK : '0);

   cmp_slice #(
      .CHUNK (CHUNK)
   ) u_slice (
      .x  (w_x),
      .y  (w_y),
      .gt (w_gt),
      .eq (w_eq)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_signed <= 1'b0;
         r_idx    <= IDX_TOP;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_gt     <= 1'b0;
         r_eq     <= 1'b0;
         r_lt     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               r_busy <= 1'b0;
               if (bus.start) begin
                  r_a      <= bus.a;
                  r_b      <= bus.b;
                  r_signed <= bus.is_signed;
                  r_idx    <= IDX_TOP;
                  r_gt     <= 1'b0;
                  r_eq     <= 1'b0;
                  r_lt     <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= CMP;
               end
            end
            CMP: begin
               if (w_gt) begin
                  r_gt    <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else if (!w_eq) begin
                  r_lt    <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else if (r_idx == '0) begin
                  r_eq    <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_idx   <= r_idx - IW'(1);
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.a_greater_b = r_gt;
   assign bus.a_equals_b  = r_eq;
   assign bus.a_smaller_b = r_lt;

endmodule

`default_nettype wire

// File: tb/tb_seq_comparator.sv
// ============================================================================
//  Module   : tb_seq_comparator
//  Purpose  : Randomized self-checking bench for seq_comparator (16-bit, 4-bit chunks).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_comparator;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;
   localparam int N     = WIDTH / CHUNK;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   seq_comparator_if #(.WIDTH(WIDTH)) bus ();

   seq_comparator #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer compare; latency from the highest differing chunk.
   function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                 output int lat, output logic [2:0] flags);
      int  va;
      int  vb;
      bit  found;
      va = s ? int'($signed(a)) : int'(a);
      vb = s ? int'($signed(b)) : int'(b);
      flags = {va > vb, va == vb, va < vb};
      lat   = N;
      found = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!found && ((a >> (i*CHUNK)) & 16'hF) != ((b >> (i*CHUNK)) & 16'hF)) begin
            lat   = N - i;
            found = 1;
         end
      end
   endfunction

   function automatic logic [2:0] obs_flags();
      return {bus.a_greater_b, bus.a_equals_b, bus.a_smaller_b};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
      tick(); tick();
      n_vec++;
      if ({bus.busy, bus.done, obs_flags()} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_state: busy/done/flags=%b required 00000",
                  {bus.busy, bus.done, obs_flags()});
      end
      rst = 1'b0;
      tick();
   endtask

   // Single compare with start pulsed, inputs scrambled after accept; expects DUT idle.
   task automatic test_directed();
      logic [15:0] ta [5] = '{16'h1234, 16'h8000, 16'h8000, 16'hFFFF, 16'h12A4};
      logic [15:0] tb [5] = '{16'h1234, 16'h7FFF, 16'h7FFF, 16'hFFFE, 16'h12B4};
      logic        ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int          tl [5] = '{4, 1, 1, 4, 3};
      logic [2:0]  tf [5] = '{3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
      int          lat;
      for (int t = 0; t < 5; t++) begin
         bus.start = 1'b1; bus.a = ta[t]; bus.b = tb[t]; bus.is_signed = ts[t];
         tick();
         bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
         bus.is_signed = ~ts[t];
         n_vec++;
         if (bus.busy !== 1'b1 || obs_flags() !== 3'b000 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL dir%0d_accept: busy=%b done=%b flags=%b required 1 0 000",
                     t, bus.busy, bus.done, obs_flags());
         end
         lat = 0;
         while (bus.done !== 1'b1 && lat < N + 2) begin
            tick();
            lat++;
         end
         n_vec++;
         if (lat != tl[t] || obs_flags() !== tf[t] || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL dir%0d_result: latency=%0d flags=%b busy=%b required %0d %b 1",
                     t, lat, obs_flags(), bus.busy, tl[t], tf[t]);
         end
         for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || obs_flags() !== tf[t]) begin
               n_err++;
               $display("FAIL dir%0d_sticky%0d: done=%b busy=%b flags=%b required 0 0 %b",
                        t, k, bus.done, bus.busy, obs_flags(), tf[t]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;
      int          elat;
      int          lat;
      logic [2:0]  ef;
      for (int t = 0; t < 40; t++) begin
         ra = 16'($urandom);
         rs = 1'($urandom);
         case ($urandom_range(0, 2))
            0:       rb = 16'($urandom);
            1:       rb = ra ^ (16'(1) << $urandom_range(0, 15));
            default: rb = ra;
         endcase
         model(ra, rb, rs, elat, ef);
         bus.start = 1'b1; bus.a = ra; bus.b = rb; bus.is_signed = rs;
         tick();
         bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
         lat = 0;
         while (bus.done !== 1'b1 && lat < N + 2) begin
            n_vec++;
            if (obs_flags() !== 3'b000 || bus.busy !== 1'b1) begin
               n_err++;
               $display("FAIL rnd%0d_inflight: flags=%b busy=%b required 000 1",
                        t, obs_flags(), bus.busy);
            end
            tick();
            lat++;
         end
         n_vec++;
         if (lat != elat || obs_flags() !== ef) begin
            n_err++;
            $display("FAIL rnd%0d_result a=%h b=%h s=%b: latency=%0d flags=%b required %0d %b",
                     t, ra, rb, rs, lat, obs_flags(), elat, ef);
         end
         tick();
      end
   endtask

   // start held high with fresh operands each cycle: only IDLE-cycle values are taken.
   task automatic test_back_to_back();
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;
      int          elat;
      logic [2:0]  ef;
      logic        exp_busy;
      logic        exp_done;
      logic [2:0]  exp_f;
      bus.start = 1'b1;
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      bus.a = ra; bus.b = rb; bus.is_signed = rs;
      for (int t = 0; t < 12; t++) begin
         model(ra, rb, rs, elat, ef);
         for (int k = 0; k <= elat + 1; k++) begin
            tick();
            if (k == elat + 1) begin
               ra = 16'($urandom);
               rb = (t % 3 == 0) ? ra : 16'($urandom);
               rs = 1'($urandom);
               bus.a = ra; bus.b = rb; bus.is_signed = rs;
            end else begin
               bus.a = 16'($urandom); bus.b = 16'($urandom); bus.is_signed = 1'($urandom);
            end
            exp_busy = (k <= elat);
            exp_done = (k == elat);
            exp_f    = (k >= elat) ? ef : 3'b000;
            n_vec++;
            if (bus.busy !== exp_busy || bus.done !== exp_done || obs_flags() !== exp_f) begin
               n_err++;
               $display("FAIL b2b%0d_cyc%0d: busy=%b done=%b flags=%b required %b %b %b",
                        t, k, bus.busy, bus.done, obs_flags(), exp_busy, exp_done, exp_f);
            end
         end
      end
      bus.start = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset_mid_cmp();
      int lat;
      bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0002; bus.is_signed = 1'b0;
      tick();
      bus.start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++;
      if ({bus.busy, bus.done, obs_flags()} !== 5'b0) begin
         n_err++;
         $display("FAIL rst_mid_cmp: busy/done/flags=%b required 00000",
                  {bus.busy, bus.done, obs_flags()});
      end
      for (int k = 0; k < N + 2; k++) begin
         tick();
         n_vec++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_done%0d: done=%b busy=%b required 0 0", k, bus.done, bus.busy);
         end
      end
      bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0002;
      tick();
      bus.start = 1'b0;
      lat = 0;
      while (bus.done !== 1'b1 && lat < N + 2) begin
         tick();
         lat++;
      end
      n_vec++;
      if (lat != 4 || obs_flags() !== 3'b001) begin
         n_err++;
         $display("FAIL rst_recover: latency=%0d flags=%b required 4 001", lat, obs_flags());
      end
      tick();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_cmp();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seq_comparator.md
# seq_comparator

Multi-cycle magnitude comparator for two WIDTH-bit operands, in signed or unsigned mode. Processes the operands MSB-first, CHUNK bits per cycle, and stops early at the first differing slice. Replaces the fixed 4-bit combinational comparator wherever operand width makes a single-cycle compare too deep. Uses a start/busy/done handshake toward the controlling FSM.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of CHUNK, otherwise elaboration fails.
- CHUNK, 4: bits compared per cycle; 1 ≤ CHUNK ≤ WIDTH.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a comparison; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned; latched with the operands.
- a  in  WIDTH  operand A; latched on start accept.
- b  in  WIDTH  operand B; latched on start accept.
- busy  out  1  high in CMP and DONE.
- done  out  1  one-cycle pulse; result flags are valid.
- a_greater_b  out  1  A > B.
- a_equals_b  out  1  A == B.
- a_smaller_b  out  1  A < B.

## Operation
- States: IDLE, CMP, DONE.
  - IDLE → CMP when start=1.
  - CMP → DONE on the first unequal slice, or after the last slice.
  - DONE → IDLE unconditionally.
- Start accept (IDLE, start=1):
  - Latch a, b and is_signed into internal registers.
  - Set the slice index to N−1, where N = WIDTH/CHUNK.
  - Clear all three flags.
- Input changes after accept have no effect.
- start in CMP or DONE is ignored and not queued.
- Each CMP cycle compares slice i, bits [i·CHUNK+CHUNK−1 : i·CHUNK], of the latched operands.
- Signed mode: invert the MSB of both operands before comparing the top slice (offset-binary trick). Lower slices compare unsigned.
- Slice result:
  - gt: set a_greater_b, go to DONE.
  - lt: set a_smaller_b, go to DONE.
  - eq and i=0: set a_equals_b, go to DONE.
  - eq and i>0: decrement i, stay in CMP.
- Exactly one flag is high after any completed compare.
- Flags are sticky: they hold through DONE and IDLE until the next start accept clears them.
- Reset values: busy=0, done=0, all three flags 0, state IDLE, slice index N−1.
- Reset in any state, including mid-CMP, aborts the compare with no done pulse.

## Timing
- Edge E0 accepts start. Edges E1..EL each compare one slice, where L is 1..N.
- done and final flags are visible in the cycle after E_L, for exactly one cycle.
- Start-to-done latency is L cycles: minimum 1 (top slice differs), maximum N (equal, or only slice 0 differs).
- Next accept is possible at edge E_L+2 (DONE → IDLE, then accept). Throughput is one compare per L+2 cycles.
- busy rises in the cycle after E0 and falls in the cycle after E_L+1.
- Flags become 0 in the cycle after an accept and stay 0 until the deciding edge.
- CHUNK=WIDTH gives L=1 always.

## Structure
- Package `seq_comparator_pkg`:
  - typedef enum `cmp_state_t` {IDLE, CMP, DONE}.
  - Function returning the slice count for a WIDTH/CHUNK pair.
- Sub-module `cmp_slice`:
  - Parameter CHUNK, purely combinational.
  - Inputs: x, y.
  - Outputs: gt, eq. lt is derived as !gt && !eq.
  - Instantiated once; the parent muxes the current slice into it.
- Top level holds the FSM, operand registers, slice index counter and flag registers.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- Unsigned, a=0x1234, b=0x1234 → a_equals_b=1, others 0, done 4 cycles after accept.
- Unsigned, a=0x8000, b=0x7FFF → a_greater_b=1, done 1 cycle after accept.
- Signed, same operands → a_smaller_b=1 (−32768 < 32767), latency 1.
- Signed, a=0xFFFF, b=0xFFFE → a_greater_b=1 (−1 > −2), latency 4.
- Unsigned, a=0x12A4, b=0x12B4 → a_smaller_b=1 at slice 1, latency 3.
- Handshake and inputs:
  - Hold start=1 continuously with new a/b every cycle.
  - Only IDLE-cycle values are accepted.
  - Back-to-back accepts are spaced L+2 cycles apart.
  - busy and done pulses match the Timing section.
- Reset:
  - Accept a=0x0001, b=0x0002, then assert rst during the second CMP cycle.
  - Required: no done pulse; flags, busy and done are 0 in the next cycle.
  - A following start completes normally.
